// File: rtl/sdram_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sdram_arbiter_if
// Brief    : Requester-side and controller-side bus of the SDRAM port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface sdram_arbiter_if #(
  parameter int NUM_PORTS = 3,
  parameter int IDX_W     = 2
);
  logic [NUM_PORTS-1:0]    p_req;
  logic [NUM_PORTS-1:0]    p_wr;
  logic [24*NUM_PORTS-1:0] p_addr;
  logic [9*NUM_PORTS-1:0]  p_burst;
  logic [16*NUM_PORTS-1:0] p_wdata;
  logic [NUM_PORTS-1:0]    p_ack;
  logic [NUM_PORTS-1:0]    p_done;
  logic [15:0]             p_rdata;
  logic                    grant_valid;
  logic [IDX_W-1:0]        grant_idx;
  logic [23:0]             mem_addr;
  logic [8:0]              mem_burst;
  logic                    mem_wr;
  logic                    mem_req;
  logic [15:0]             mem_wdata;
  logic                    mem_ack;
  logic [15:0]             mem_rdata;

  modport slave (
    input  p_req, p_wr, p_addr, p_burst, p_wdata, mem_ack, mem_rdata,
    output p_ack, p_done, p_rdata, grant_valid, grant_idx,
           mem_addr, mem_burst, mem_wr, mem_req, mem_wdata
  );

  modport master (
    output p_req, p_wr, p_addr, p_burst, p_wdata, mem_ack, mem_rdata,
    input  p_ack, p_done, p_rdata, grant_valid, grant_idx,
           mem_addr, mem_burst, mem_wr, mem_req, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sdram_arbiter
// Brief    : Round-robin sharing of one SDRAM controller port, one burst per
//            grant, end of burst found by counting controller acks.
//            Optional macro SDRAM_ARB_PRIO0_EN gives port 0 absolute priority.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
  parameter int NUM_PORTS = 3,
  parameter int IDX_W     = 2
) (
  input  logic           clk,
  input  logic           res,
  sdram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_BUSY = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] c_last_port = IDX_W'(NUM_PORTS - 1);

  state_t                r_state,       w_state;
  logic [23:0]           r_mem_addr,    w_mem_addr;
  logic [8:0]            r_mem_burst,   w_mem_burst;
  logic                  r_mem_wr,      w_mem_wr;
  logic                  r_mem_req,     w_mem_req;
  logic                  r_grant_valid, w_grant_valid;
  logic [IDX_W-1:0]      r_grant_idx,   w_grant_idx;
  logic [9:0]            r_target,      w_target;
  logic [9:0]            r_count,       w_count;
  logic [NUM_PORTS-1:0]  r_p_done,      w_p_done;

  logic                  w_sel_found;
  logic [IDX_W-1:0]      w_sel_idx;
  logic [IDX_W-1:0]      w_cand;
  logic [23:0]           w_sel_addr;
  logic [8:0]            w_sel_burst;
  logic                  w_sel_wr;
  logic [15:0]           w_wdata;

  // Scan from the port after the last owner so every requester gets a turn.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = r_grant_idx;
    w_cand      = r_grant_idx;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      w_cand = IDX_W'((int'(r_grant_idx) + i) % NUM_PORTS);
      if (!w_sel_found && bus.p_req[w_cand]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_cand;
      end
    end
`ifdef SDRAM_ARB_PRIO0_EN
    if (bus.p_req[0]) begin
      w_sel_found = 1'b1;
      w_sel_idx   = '0;
    end
`endif
  end

  always_comb begin
    w_sel_addr  = '0;
    w_sel_burst = '0;
    w_sel_wr    = 1'b0;
    w_wdata     = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (w_sel_idx == IDX_W'(k)) begin
        w_sel_addr  = bus.p_addr[k*24 +: 24];
        w_sel_burst = bus.p_burst[k*9 +: 9];
        w_sel_wr    = bus.p_wr[k];
      end
      if (r_grant_idx == IDX_W'(k)) begin
        w_wdata = bus.p_wdata[k*16 +: 16];
      end
    end
  end

  always_comb begin
    w_state       = r_state;
    w_mem_addr    = r_mem_addr;
    w_mem_burst   = r_mem_burst;
    w_mem_wr      = r_mem_wr;
    w_mem_req     = r_mem_req;
    w_grant_valid = r_grant_valid;
    w_grant_idx   = r_grant_idx;
    w_target      = r_target;
    w_count       = r_count;
    w_p_done      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_sel_found) begin
          w_mem_addr    = w_sel_addr;
          w_mem_burst   = w_sel_burst;
          w_mem_wr      = w_sel_wr;
          w_target      = {1'b0, w_sel_burst} + 10'd1;
          w_count       = '0;
          w_grant_idx   = w_sel_idx;
          w_grant_valid = 1'b1;
          w_mem_req     = 1'b1;
          w_state       = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_ack) begin
          w_mem_req = 1'b0;
          w_count   = 10'd1;
          if (r_target == 10'd1) begin
            w_grant_valid = 1'b0;
            w_p_done      = NUM_PORTS'(1) << r_grant_idx;
            w_state       = S_DONE;
          end else begin
            w_state = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (bus.mem_ack) begin
          w_count = r_count + 10'd1;
          if (r_count == r_target - 10'd1) begin
            w_grant_valid = 1'b0;
            w_p_done      = NUM_PORTS'(1) << r_grant_idx;
            w_state       = S_DONE;
          end
        end
      end
      default: begin
        // One forced idle cycle between grants.
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state       <= S_IDLE;
      r_mem_addr    <= '0;
      r_mem_burst   <= '0;
      r_mem_wr      <= 1'b0;
      r_mem_req     <= 1'b0;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= c_last_port;
      r_target      <= '0;
      r_count       <= '0;
      r_p_done      <= '0;
    end else begin
      r_state       <= w_state;
      r_mem_addr    <= w_mem_addr;
      r_mem_burst   <= w_mem_burst;
      r_mem_wr      <= w_mem_wr;
      r_mem_req     <= w_mem_req;
      r_grant_valid <= w_grant_valid;
      r_grant_idx   <= w_grant_idx;
      r_target      <= w_target;
      r_count       <= w_count;
      r_p_done      <= w_p_done;
    end
  end

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_ack
    assign bus.p_ack[k] = bus.mem_ack & r_grant_valid & (r_grant_idx == IDX_W'(k));
  end

  assign bus.p_done      = r_p_done;
  assign bus.p_rdata     = bus.mem_rdata;
  assign bus.grant_valid = r_grant_valid;
  assign bus.grant_idx   = r_grant_idx;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_burst   = r_mem_burst;
  assign bus.mem_wr      = r_mem_wr;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_wdata   = w_wdata;
endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sdram_arbiter
// Brief    : Scoreboard bench: requester and controller models, a grant-order
//            reference model and a monitor that checks every ack and done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;
  localparam int NUM_PORTS = 3;
  localparam int IDX_W     = 2;

  typedef struct {
    int          port;
    bit          wr;
    logic [23:0] addr;
    int          burst;
    bit          drop;
  } job_t;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  sdram_arbiter_if #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) bus ();
  sdram_arbiter #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  job_t jobs[NUM_PORTS][$];
  job_t exp_q[$];
  int   wcnt[NUM_PORTS];
  bit   dropped[NUM_PORTS];
  int   model_last = NUM_PORTS - 1;
  int   compared = 0;
  int   mismatched = 0;

  logic [NUM_PORTS-1:0] ack_s = '0, done_s = '0;
  logic                 gv_s = 1'b0, gv_prev = 1'b0;
  logic [IDX_W-1:0]     gi_s = '0;
  int                   mon_acks = 0;
  bit                   pend_done = 1'b0, idle_chk = 1'b0;
  int                   pend_port = 0;

  function automatic logic [15:0] rd_word(logic [23:0] a);
    return a[15:0] ^ {a[23:16], a[7:0]} ^ 16'h3C5A;
  endfunction

  function automatic logic [15:0] wd_word(int k, logic [23:0] a, int n);
    logic [23:0] t;
    t = 24'(a + 24'(n));
    return t[15:0] ^ (16'(k) << 12) ^ 16'h0A51;
  endfunction

  function automatic logic [NUM_PORTS-1:0] onehot(int k);
    logic [NUM_PORTS-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_msg(string name, string what);
    compared++;
    mismatched++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endfunction

  function automatic int pending_jobs();
    int s = 0;
    for (int k = 0; k < NUM_PORTS; k++) s += jobs[k].size();
    return s;
  endfunction

  // Reference order: every port holding jobs is requesting at each decision.
  function automatic void plan();
    int idx[NUM_PORTS];
    int rem;
    int pick;
    rem = pending_jobs();
    for (int k = 0; k < NUM_PORTS; k++) idx[k] = 0;
    while (rem > 0) begin
      pick = -1;
`ifdef SDRAM_ARB_PRIO0_EN
      if (idx[0] < jobs[0].size()) pick = 0;
`endif
      for (int i = 1; i <= NUM_PORTS; i++) begin
        int k;
        k = (model_last + i) % NUM_PORTS;
        if (pick < 0 && idx[k] < jobs[k].size()) pick = k;
      end
      exp_q.push_back(jobs[pick][idx[pick]]);
      idx[pick]++;
      model_last = pick;
      rem--;
    end
  endfunction

  function automatic void flush();
    for (int k = 0; k < NUM_PORTS; k++) begin
      jobs[k].delete();
      wcnt[k] = 0;
      dropped[k] = 1'b0;
    end
    exp_q.delete();
  endfunction

  function automatic void add_job(int k, bit wr, logic [23:0] a, int b, bit drop);
    job_t j;
    j.port = k; j.wr = wr; j.addr = a; j.burst = b; j.drop = drop;
    jobs[k].push_back(j);
  endfunction

  task automatic drive_ports();
    job_t j;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (jobs[k].size() > 0) begin
        j = jobs[k][0];
        bus.p_req[k]             = !dropped[k];
        bus.p_wr[k]              = j.wr;
        bus.p_addr[k*24 +: 24]   = j.addr;
        bus.p_burst[k*9 +: 9]    = 9'(j.burst);
        bus.p_wdata[k*16 +: 16]  = wd_word(k, j.addr, wcnt[k]);
      end else begin
        bus.p_req[k]             = 1'b0;
        bus.p_wr[k]              = 1'b0;
        bus.p_addr[k*24 +: 24]   = '0;
        bus.p_burst[k*9 +: 9]    = '0;
        bus.p_wdata[k*16 +: 16]  = '0;
      end
    end
  endtask

  task automatic check_reset(string tag);
    check({tag, "_mem_req"},     32'(bus.mem_req), 0);
    check({tag, "_mem_wr"},      32'(bus.mem_wr), 0);
    check({tag, "_grant_valid"}, 32'(bus.grant_valid), 0);
    check({tag, "_p_done"},      32'(bus.p_done), 0);
    check({tag, "_p_ack"},       32'(bus.p_ack), 0);
    check({tag, "_mem_addr"},    32'(bus.mem_addr), 0);
    check({tag, "_mem_burst"},   32'(bus.mem_burst), 0);
    check({tag, "_grant_idx"},   32'(bus.grant_idx), NUM_PORTS - 1);
  endtask

  task automatic wait_idle(string name, int budget);
    int c = 0;
    while ((exp_q.size() != 0 || pending_jobs() != 0) && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (c >= budget) begin
      fail_msg(name, $sformatf("timeout with %0d transactions outstanding, expected 0", exp_q.size()));
      flush();
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  // Requester models: hold request until done, advance write data on each ack.
  initial begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      wcnt[k] = 0;
      dropped[k] = 1'b0;
    end
    drive_ports();
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (jobs[k].size() > 0) begin
          if (ack_s[k]) wcnt[k]++;
          if (done_s[k]) begin
            void'(jobs[k].pop_front());
            wcnt[k] = 0;
            dropped[k] = 1'b0;
          end else if (gv_s && gi_s == IDX_W'(k) && jobs[k][0].drop) begin
            dropped[k] = 1'b1;
          end
        end
      end
      drive_ports();
    end
  end

  // Controller model: burst+1 acks with random gaps, sometimes a stray ack after.
  initial begin
    logic [23:0] a;
    int          b;
    int          gap;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!res && bus.mem_req) begin
        a = bus.mem_addr;
        b = int'(bus.mem_burst);
        @(posedge clk);
        #1;
        for (int n = 0; n <= b; n++) begin
          gap = $urandom_range(0, 2);
          for (int g = 0; g < gap && !res; g++) begin
            @(posedge clk);
            #1;
          end
          if (res) break;
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rd_word(24'(a + 24'(n)));
          @(posedge clk);
          #1;
          bus.mem_ack = 1'b0;
          if (res) break;
        end
        if (!res && $urandom_range(0, 1) == 1) begin
          bus.mem_ack = 1'b1;
          @(posedge clk);
          #1;
          bus.mem_ack = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on p_done and checks every ack against it.
  initial begin
    job_t cur;
    forever begin
      @(negedge clk);
      ack_s  = bus.p_ack;
      done_s = bus.p_done;
      gv_s   = bus.grant_valid;
      gi_s   = bus.grant_idx;
      if (res) begin
        mon_acks = 0; pend_done = 1'b0; idle_chk = 1'b0; gv_prev = 1'b0;
      end else begin
        if (pend_done) begin
          check("done_pulse", 32'(done_s), 32'(onehot(pend_port)));
          check("ack_in_done", 32'(ack_s), 0);
          check("gv_in_done", 32'(gv_s), 0);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          pend_done = 1'b0;
          idle_chk  = 1'b1;
          mon_acks  = 0;
        end else begin
          if (idle_chk) begin
            check("idle_gap_gv", 32'(gv_s), 0);
            idle_chk = 1'b0;
          end
          if (done_s != '0) check("stray_done", 32'(done_s), 0);
          if (gv_s && !gv_prev) begin
            mon_acks = 0;
            if (exp_q.size() == 0) begin
              fail_msg("grant_unexpected", $sformatf("grant to %0d, expected none", gi_s));
            end else begin
              cur = exp_q[0];
              check("grant_idx", 32'(gi_s), cur.port);
              check("mem_addr", 32'(bus.mem_addr), 32'(cur.addr));
              check("mem_burst", 32'(bus.mem_burst), cur.burst);
              check("mem_wr", 32'(bus.mem_wr), 32'(cur.wr));
            end
          end
          if (gv_s && exp_q.size() > 0) check("mem_req", 32'(bus.mem_req), 32'(mon_acks == 0));
          if (ack_s != '0) begin
            if (exp_q.size() == 0 || !gv_s) begin
              fail_msg("ack_unexpected", $sformatf("p_ack=0x%0h, expected 0", ack_s));
            end else begin
              cur = exp_q[0];
              check("ack_port", 32'(ack_s), 32'(onehot(cur.port)));
              if (cur.wr) check("wdata", 32'(bus.mem_wdata), 32'(wd_word(cur.port, cur.addr, mon_acks)));
              else        check("rdata", 32'(bus.p_rdata), 32'(rd_word(24'(cur.addr + 24'(mon_acks)))));
              mon_acks++;
              if (mon_acks == cur.burst + 1) begin
                pend_done = 1'b1;
                pend_port = cur.port;
              end
            end
          end
        end
        gv_prev = gv_s;
      end
    end
  end

  // Stimulus
  initial begin
    int guard;
    res = 1'b0;
    #2;
    res = 1'b1;
    #1;
    check_reset("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    res = 1'b0;
    @(posedge clk);
    #2;

    add_job(1, 1'b0, 24'h000100, 3, 1'b0);
    plan();
    wait_idle("read_p1", 200);

    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NUM_PORTS; k++)
        add_job(k, 1'b1, 24'($urandom), 0, 1'b0);
    plan();
    wait_idle("rr_writes", 400);

    add_job(2, 1'b1, 24'hFFFF80, 511, 1'b0);
    plan();
    wait_idle("long_burst", 3000);

    add_job(1, 1'b0, 24'h123456, 5, 1'b1);
    plan();
    wait_idle("drop_req", 300);

    add_job(2, 1'b1, 24'h00ABC0, 40, 1'b0);
    plan();
    guard = 0;
    while (!(gv_s && mon_acks >= 5) && guard < 400) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 400) fail_msg("abort_setup", "5 acks not reached, expected within 400 cycles");
    @(negedge clk);
    #2;
    res = 1'b1;
    #1;
    check_reset("abort");
    flush();
    model_last = NUM_PORTS - 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b0;
    @(posedge clk);
    #2;

    for (int k = 0; k < NUM_PORTS; k++)
      add_job(k, k[0], 24'($urandom), int'($urandom_range(0, 6)), 1'b0);
    plan();
    wait_idle("after_abort", 400);

    for (int r = 0; r < 4; r++) add_job(0, 1'b0, 24'($urandom), 1, 1'b0);
    for (int r = 0; r < 2; r++) add_job(1, 1'b1, 24'($urandom), 2, 1'b0);
    plan();
    wait_idle("prio_mix", 600);

    for (int ph = 0; ph < 6; ph++) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        int n;
        n = int'($urandom_range(0, 2));
        for (int j = 0; j < n; j++)
          add_job(k, 1'($urandom), 24'($urandom), int'($urandom_range(0, 12)), 1'b0);
      end
      if (pending_jobs() == 0) add_job(int'($urandom_range(0, NUM_PORTS - 1)), 1'b0, 24'($urandom), 2, 1'b0);
      plan();
      wait_idle("random", 1500);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
